// File: rtl/range_sequencer.sv
// Round-robin shared counting engine: one requester at a time owns a bounded up/down count run.
// Operands are captured at grant, and every output is driven from a flop.
module range_sequencer #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] start_val,
    input  logic [NREQ*W-1:0] limit_val,
    input  logic [NREQ*4-1:0] step,
    input  logic [NREQ-1:0]   dir,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [W-1:0]      count,
    output logic              count_valid,
    output logic [NREQ-1:0]   done,
    output logic              aborted
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [W-1:0]    limit_q, limit_d;
    logic [3:0]      step_q, step_d;
    logic            dir_q, dir_d;
    logic [W-1:0]    count_q, count_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            busy_q, busy_d;
    logic            cv_q, cv_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    int              cand;

    logic [W:0]      sum_ext;
    logic [W-1:0]    step_w;
    logic            up_ok, dn_ok, cont;
    logic [W-1:0]    next_val;

    // Round-robin search starting at the pointer, ascending with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = (int'(ptr_q) + k) % int'(NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Continuation test on latched operands; widened sum keeps the up direction from wrapping
    always_comb begin
        step_w   = W'(step_q);
        sum_ext  = (W+1)'(count_q) + (W+1)'(step_q);
        up_ok    = sum_ext <= {1'b0, limit_q};
        dn_ok    = (count_q >= step_w) && ((count_q - step_w) >= limit_q);
        cont     = (step_q != 4'd0) && (dir_q ? up_ok : dn_ok);
        next_val = dir_q ? sum_ext[W-1:0] : (count_q - step_w);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        limit_d   = limit_q;
        step_d    = step_q;
        dir_d     = dir_q;
        count_d   = count_q;
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        busy_d    = 1'b0;
        cv_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_RUN;
                    owner_d = win_idx;
                    count_d = start_val[int'(win_idx)*W +: W];
                    limit_d = limit_val[int'(win_idx)*W +: W];
                    step_d  = step[int'(win_idx)*4 +: 4];
                    dir_d   = dir[win_idx];
                    gnt_d   = NREQ'(1) << win_idx;
                    busy_d  = 1'b1;
                    cv_d    = 1'b1;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (cont && req[owner_q]) begin
                    count_d = next_val;
                    gnt_d   = gnt_q;
                    cv_d    = 1'b1;
                end else begin
                    // Natural end takes precedence over a simultaneous request drop
                    state_d   = S_DONE;
                    done_d    = gnt_q;
                    aborted_d = cont;
                    ptr_d     = IW'((int'(owner_q) + 1) % int'(NREQ));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            limit_q   <= '0;
            step_q    <= '0;
            dir_q     <= 1'b0;
            count_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            cv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            limit_q   <= limit_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            count_q   <= count_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            cv_q      <= cv_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign count       = count_q;
    assign count_valid = cv_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_range_sequencer.sv
// Directed bench for range_sequencer: count sequences, limits, round-robin, abort and async reset.
module tb_range_sequencer;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] start_val = '0;
    logic [NREQ*W-1:0] limit_val = '0;
    logic [NREQ*4-1:0] step = '0;
    logic [NREQ-1:0]   dir = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [W-1:0]      count;
    logic              count_valid;
    logic [NREQ-1:0]   done;
    logic              aborted;

    int n_cmp = 0;
    int n_err = 0;

    range_sequencer #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .start_val(start_val), .limit_val(limit_val),
        .step(step), .dir(dir), .gnt(gnt), .busy(busy), .count(count),
        .count_valid(count_valid), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int r, input logic [15:0] s, input logic [15:0] l,
                           input logic [3:0] st, input logic d);
        start_val[r*16 +: 16] = s;
        limit_val[r*16 +: 16] = l;
        step[r*4 +: 4]        = st;
        dir[r]                = d;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cv"}, 32'(count_valid), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_abort"}, 32'(aborted), 0);
    endtask

    // One full run: every emitted value checked against start +/- n*step, then the DONE cycle
    task automatic do_run(input string tag, input int r, input logic [15:0] s, input logic [15:0] l,
                          input logic [3:0] st, input logic d, input int exp_n,
                          input logic [15:0] exp_last);
        int n;
        int guard;
        logic [15:0] expv;
        logic [15:0] last;
        @(negedge clk);
        set_ops(r, s, l, st, d);
        req = 4'b0001 << r;
        @(negedge clk);
        n = 0;
        guard = 0;
        last = '0;
        while (count_valid && guard < 300) begin
            expv = d ? 16'(int'(s) + n * int'(st)) : 16'(int'(s) - n * int'(st));
            check({tag, "_cnt"}, 32'(count), 32'(expv));
            check({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << r));
            last = count;
            n++;
            if (n == 1) set_ops(r, 16'h0, 16'h0, 4'h0, ~d);
            @(negedge clk);
            guard++;
        end
        check({tag, "_timeout"}, 32'(guard >= 300), 0);
        check({tag, "_nvals"}, 32'(n), 32'(exp_n));
        check({tag, "_last"}, 32'(last), 32'(exp_last));
        check({tag, "_done"}, 32'(done), 32'(4'b0001 << r));
        check({tag, "_abort"}, 32'(aborted), 0);
        check({tag, "_busy_done"}, 32'(busy), 1);
        check({tag, "_gnt_done"}, 32'(gnt), 0);
        check({tag, "_hold"}, 32'(count), 32'(exp_last));
        req = '0;
        @(negedge clk);
        check_idle_zero({tag, "_idle"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        logic [3:0] exp_g;
        #1;
        check_idle_zero("reset");
        check("reset_count", 32'(count), 0);
        @(negedge clk);
        rst = 1'b0;

        do_run("up0_40", 0, 16'd0, 16'd40, 4'd2, 1'b1, 21, 16'd40);
        do_run("dn93_5", 2, 16'd93, 16'd5, 4'd4, 1'b0, 23, 16'd5);
        do_run("up350", 2, 16'd350, 16'd370, 4'd3, 1'b1, 7, 16'd368);
        do_run("nowrap_up", 0, 16'd65530, 16'd65535, 4'd4, 1'b1, 2, 16'd65534);
        do_run("nowrap_dn", 0, 16'd3, 16'd0, 4'd4, 1'b0, 1, 16'd3);
        do_run("beyond", 3, 16'd50, 16'd10, 4'd1, 1'b1, 1, 16'd50);

        // Round-robin with two requesters held high, step 0 gives one value each
        do_reset();
        set_ops(1, 16'd7, 16'd7, 4'd0, 1'b1);
        set_ops(3, 16'd9, 16'd9, 4'd0, 1'b1);
        req = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 4'b0010 : 4'b1000;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (gnt == 0 && guard < 6);
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            check("rr_cnt", 32'(count), (g % 2 == 0) ? 32'd7 : 32'd9);
            check("rr_cv", 32'(count_valid), 1);
            @(negedge clk);
            check("rr_done", 32'(done), 32'(exp_g));
            check("rr_abort", 32'(aborted), 0);
            check("rr_cv_done", 32'(count_valid), 0);
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("rr_idle");

        // Abort after three emitted values
        set_ops(1, 16'd0, 16'd100, 4'd1, 1'b1);
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ab_cnt", 32'(count), 32'(k));
            check("ab_cv", 32'(count_valid), 1);
        end
        req = '0;
        @(negedge clk);
        check("ab_done", 32'(done), 32'b0010);
        check("ab_abort", 32'(aborted), 1);
        check("ab_hold", 32'(count), 2);
        check("ab_busy", 32'(busy), 1);
        check("ab_gnt", 32'(gnt), 0);
        @(negedge clk);
        check_idle_zero("ab_idle");

        // Asynchronous reset in the middle of a run
        set_ops(0, 16'd0, 16'd1000, 4'd1, 1'b1);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        check("rst_pre_cv", 32'(count_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("rst_async");
        check("rst_async_count", 32'(count), 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_after");
        do_run("post_rst", 0, 16'd5, 16'd6, 4'd1, 1'b1, 2, 16'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
